// File: rtl/rr_latency_grant_sched_if.sv
// Request/grant bundle between requester agents (master) and the round-robin scheduler (slave).
interface rr_latency_grant_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();
  logic [NUM_REQ-1:0] req;
  logic               fast_mode;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;
  logic               timeout;

  modport master (output req, fast_mode, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, fast_mode, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/rr_latency_grant_sched.sv
// Round-robin scheduler with per-arbitration 1- or 2-cycle grant latency and a hold-limit release.
// Optional embedded assertions/covers are compiled when RR_GRANT_SVA_EN is defined.
module rr_latency_grant_sched #(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 8,
  parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic                     clk,
  input logic                     rst_n,
  rr_latency_grant_sched_if.slave bus
);
  localparam int                 CNT_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [ID_W:0]      NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [ID_W-1:0]    r_gnt_id;
  logic               r_busy;
  logic               r_timeout;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic               r_lat_sel;

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [ID_W-1:0]      w_offset;
  logic [ID_W:0]        w_sum;
  logic [ID_W:0]        w_wrap;
  logic [ID_W-1:0]      w_winner;
  logic [ID_W-1:0]      w_next_ptr;
  logic                 w_owner_req;

  // Rotate requests so rr_ptr lands on bit 0; the lowest set bit is then the winner's offset.
  assign w_req_dbl = {bus.req, bus.req};
  assign w_req_rot = NUM_REQ'(w_req_dbl >> r_rr_ptr);

  always_comb begin
    w_offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_offset = ID_W'(k);
    end
  end

  assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_offset};
  assign w_wrap      = w_sum - NUM_REQ_W;
  assign w_winner    = (w_sum >= NUM_REQ_W) ? w_wrap[ID_W-1:0] : w_sum[ID_W-1:0];
  assign w_next_ptr  = (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + ID_W'(1);
  assign w_owner_req = bus.req[r_gnt_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
      r_lat_sel  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_gnt_id  <= w_winner;
            r_lat_sel <= bus.fast_mode;
            r_busy    <= 1'b1;
            if (bus.fast_mode) begin
              r_state <= S_GRANT;
              r_gnt   <= ONE_HOT0 << w_winner;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Winner gave up before its slow-latency grant: no tenure, pointer stays put.
          if (!w_owner_req) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (!r_lat_sel) begin
            r_state <= S_GRANT;
            r_gnt   <= ONE_HOT0 << r_gnt_id;
          end
        end
        S_GRANT: begin
          if (!w_owner_req || r_hold_cnt == HOLD_LAST) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= w_owner_req;
            r_rr_ptr   <= w_next_ptr;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

`ifdef RR_GRANT_SVA_EN
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.gnt));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sva
    a_fast_lat: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == S_IDLE && (|bus.req) && w_winner == ID_W'(gi) && bus.fast_mode) |=> bus.gnt[gi]);
    a_slow_lat: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == S_IDLE && (|bus.req) && w_winner == ID_W'(gi) && !bus.fast_mode)
        |=> (bus.req[gi] |=> bus.gnt[gi]));
  end

  a_tenure: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(|bus.gnt) |-> ##[1:HOLD_MAX] !(|bus.gnt));
  a_timeout: assert property (@(posedge clk) disable iff (!rst_n)
    bus.timeout |-> $past(r_state == S_GRANT && r_hold_cnt == HOLD_LAST && w_owner_req));

  c_abort: cover property (@(posedge clk) disable iff (!rst_n) r_state == S_WAIT && !w_owner_req);
  c_timeout: cover property (@(posedge clk) disable iff (!rst_n) bus.timeout);
  c_ptr_wrap: cover property (@(posedge clk) disable iff (!rst_n)
    r_state == S_GRANT && r_gnt_id == LAST_ID && (!w_owner_req || r_hold_cnt == HOLD_LAST));
`endif
endmodule
